// File: rtl/sys_controller_if.sv
// Valid/ready byte-word port pair between the system-call controller and its I/O peer.
// The controller owns the master view; the peer (device model or bench) owns the slave view.
interface sys_controller_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sys_controller.sv
// System-call controller: stalls the CPU on a syscall, services output/input
// transfers over the I/O port, writes input words back into r3, then resumes.
module sys_controller (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  sys_signal,
  input  logic [47:0]           sysregs,
  sys_controller_if.master      io,
  output logic                  cpu_clk_en,
  output logic                  cpu_clear,
  output logic                  load_signal,
  output logic [15:0]           load_data,
  output logic                  halted,
  output logic                  err,
  output logic [15:0]           sys_count
);

  localparam logic [2:0] ST_BOOT     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_DECODE   = 3'd2;
  localparam logic [2:0] ST_OUT_WAIT = 3'd3;
  localparam logic [2:0] ST_IN_WAIT  = 3'd4;
  localparam logic [2:0] ST_LOAD     = 3'd5;
  localparam logic [2:0] ST_RESUME   = 3'd6;
  localparam logic [2:0] ST_HALT     = 3'd7;

  logic [2:0]  state_reg, state_next;
  logic        boot_cnt_reg;
  logic [15:0] code_reg;
  logic [15:0] arg_reg;
  logic [15:0] in_word_reg;
  logic        err_reg;
  logic [15:0] count_reg;

  // r3 is only ever written by the controller, never read.
  logic unused_r3;
  assign unused_r3 = ^sysregs[47:32];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT:     if (boot_cnt_reg) state_next = ST_RUN;
      ST_RUN:      if (sys_signal) state_next = ST_DECODE;
      ST_DECODE: begin
        case (code_reg)
          16'd0:   state_next = ST_HALT;
          16'd1:   state_next = ST_OUT_WAIT;
          16'd2:   state_next = ST_IN_WAIT;
          16'd3:   state_next = ST_OUT_WAIT;
          default: state_next = ST_RESUME;
        endcase
      end
      ST_OUT_WAIT: if (io.out_ready) state_next = (code_reg == 16'd3) ? ST_IN_WAIT : ST_RESUME;
      ST_IN_WAIT:  if (io.in_valid) state_next = ST_LOAD;
      ST_LOAD:     state_next = ST_RESUME;
      ST_RESUME:   state_next = ST_RUN;
      ST_HALT:     state_next = ST_HALT;
      default:     state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg    <= ST_BOOT;
      boot_cnt_reg <= 1'b0;
      code_reg     <= '0;
      arg_reg      <= '0;
      in_word_reg  <= '0;
      err_reg      <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_BOOT) boot_cnt_reg <= 1'b1;
      if (state_reg == ST_RUN && sys_signal) begin
        code_reg <= sysregs[15:0];
        arg_reg  <= sysregs[31:16];
      end
      if (state_reg == ST_IN_WAIT && io.in_valid) in_word_reg <= io.in_data;
      if (state_reg == ST_DECODE && code_reg > 16'd3) err_reg <= 1'b1;
      // Count on entry so HALT (which never leaves) is counted exactly once.
      if ((state_next == ST_RESUME || state_next == ST_HALT) && state_next != state_reg)
        count_reg <= count_reg + 16'd1;
    end
  end

  // Every output is a decode of registered state; nothing combinational from inputs.
  always_comb begin
    cpu_clear    = (state_reg == ST_BOOT);
    cpu_clk_en   = (state_reg == ST_BOOT) || (state_reg == ST_RUN) || (state_reg == ST_RESUME);
    load_signal  = (state_reg == ST_LOAD);
    io.in_ready  = (state_reg == ST_IN_WAIT);
    io.out_valid = (state_reg == ST_OUT_WAIT);
    halted       = (state_reg == ST_HALT);
    err          = err_reg;
    sys_count    = count_reg;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_data_gate
      assign io.out_data[gi] = io.out_valid & arg_reg[gi];
      assign load_data[gi]   = load_signal & in_word_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_sys_controller.sv
// Directed bench for sys_controller: table of syscall vectors plus hand-written
// reset, clear-during-transfer, back-to-back and halt sequences.
module tb_sys_controller;
  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        sys_signal = 1'b0;
  logic [47:0] sysregs = '0;
  logic        cpu_clk_en, cpu_clear, load_signal, halted, err;
  logic [15:0] load_data, sys_count;

  sys_controller_if io ();

  sys_controller dut (
    .clk         (clk),
    .clear       (clear),
    .sys_signal  (sys_signal),
    .sysregs     (sysregs),
    .io          (io),
    .cpu_clk_en  (cpu_clk_en),
    .cpu_clear   (cpu_clear),
    .load_signal (load_signal),
    .load_data   (load_data),
    .halted      (halted),
    .err         (err),
    .sys_count   (sys_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [15:0] code;
    logic [15:0] arg;
    logic [15:0] in_word;
    int          out_delay;
    int          in_delay;
    int          exp_resume;
    int          exp_out_cycles;
    int          exp_loads;
    logic [15:0] exp_load;
    logic        exp_err;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int hold);
    int n;
    clear = 1'b1;
    repeat (hold) tick();
    check("rst_cpu_clear", {31'd0, cpu_clear}, 32'd1);
    check("rst_clk_en", {31'd0, cpu_clk_en}, 32'd1);
    check("rst_status", {13'd0, halted, err, io.out_valid, sys_count}, 32'd0);
    check("rst_load", {15'd0, load_signal, load_data}, 32'd0);
    clear = 1'b0;
    n = 0;
    while (cpu_clear && n < 10) begin
      n++;
      tick();
    end
    check("boot_cycles", n, 32'd2);
    check("run_clk_en", {31'd0, cpu_clk_en}, 32'd1);
    $display("reset hold=%0d boot_cycles=%0d clk_en=%0b count=%0h", hold, n, cpu_clk_en, sys_count);
  endtask

  task automatic run_vec(input int i);
    int ov_cnt = 0, ir_cnt = 0, loads = 0, resume_cyc = 0, out_bad = 0, load_bad = 0;
    logic [15:0] ld = '0;
    io.out_ready = 1'b0;
    io.in_valid  = 1'b0;
    sysregs    = {16'hDEAD, vecs[i].arg, vecs[i].code};
    sys_signal = 1'b1;
    tick();
    sys_signal = 1'b0;
    sysregs    = '0;
    check("decode_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    for (int cyc = 1; cyc <= 40 && resume_cyc == 0; cyc++) begin
      if (cyc > 1) tick();
      io.out_ready = 1'b0;
      io.in_valid  = 1'b0;
      io.in_data   = '0;
      if (io.out_valid) begin
        ov_cnt++;
        if (io.out_data !== vecs[i].arg) out_bad++;
        if (ov_cnt > vecs[i].out_delay) io.out_ready = 1'b1;
      end else if (io.out_data !== 16'd0) out_bad++;
      if (io.in_ready) begin
        ir_cnt++;
        if (ir_cnt > vecs[i].in_delay) begin
          io.in_valid = 1'b1;
          io.in_data  = vecs[i].in_word;
        end
      end
      if (load_signal) begin
        loads++;
        ld = load_data;
      end else if (load_data !== 16'd0) load_bad++;
      if (cpu_clk_en) resume_cyc = cyc;
    end
    io.out_ready = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    check("resume_cycle", resume_cyc, vecs[i].exp_resume);
    check("out_cycles", ov_cnt, vecs[i].exp_out_cycles);
    check("out_stable", out_bad, 32'd0);
    check("load_count", loads, vecs[i].exp_loads);
    check("load_gated", load_bad, 32'd0);
    if (vecs[i].exp_loads > 0) check("load_data", {16'd0, ld}, {16'd0, vecs[i].exp_load});
    check("err", {31'd0, err}, {31'd0, vecs[i].exp_err});
    check("sys_count", {16'd0, sys_count}, {16'd0, vecs[i].exp_count});
    tick();
    check("back_to_run", {30'd0, cpu_clk_en, cpu_clear}, 32'd2);
    $display("call %0d code=%0h arg=%0h resume=%0d out=%0d loads=%0d ld=%0h err=%0b count=%0h",
             i, vecs[i].code, vecs[i].arg, resume_cyc, ov_cnt, loads, ld, err, sys_count);
  endtask

  initial begin
    int halt_bad;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;

    //          code    arg      in_word  od id res oc ld exp_load err count
    vecs[0] = '{16'd1, 16'h1234, 16'h0000, 4, 0, 7, 5, 0, 16'h0000, 1'b0, 16'd1};
    vecs[1] = '{16'd2, 16'h0000, 16'hBEEF, 0, 0, 4, 0, 1, 16'hBEEF, 1'b0, 16'd2};
    vecs[2] = '{16'd3, 16'h00FF, 16'h0007, 0, 0, 5, 1, 1, 16'h0007, 1'b0, 16'd3};
    vecs[3] = '{16'd1, 16'hA5A5, 16'h0000, 0, 0, 3, 1, 0, 16'h0000, 1'b0, 16'd4};
    vecs[4] = '{16'd2, 16'h0000, 16'h1357, 0, 3, 7, 0, 1, 16'h1357, 1'b0, 16'd5};
    vecs[5] = '{16'd3, 16'hFFFF, 16'h8001, 2, 1, 8, 3, 1, 16'h8001, 1'b0, 16'd6};
    vecs[6] = '{16'd9, 16'h0000, 16'h0000, 0, 0, 2, 0, 0, 16'h0000, 1'b1, 16'd7};
    vecs[7] = '{16'h8000, 16'h0000, 16'h0000, 0, 0, 2, 0, 0, 16'h0000, 1'b1, 16'd8};

    do_reset(3);
    for (int i = 0; i < 8; i++) run_vec(i);

    // Clear while an output word is pending.
    sysregs    = {16'h0, 16'h4321, 16'd1};
    sys_signal = 1'b1;
    tick();
    sys_signal = 1'b0;
    tick();
    tick();
    check("mid_out_valid", {15'd0, io.out_valid, io.out_data}, {15'd0, 1'b1, 16'h4321});
    clear = 1'b1;
    tick();
    check("clr_out_valid", {15'd0, io.out_valid, io.out_data}, 32'd0);
    check("clr_status", {14'd0, err, halted, sys_count}, 32'd0);
    check("clr_cpu_clear", {31'd0, cpu_clear}, 32'd1);
    $display("clear mid-out: out_valid=%0b out_data=%0h count=%0h", io.out_valid, io.out_data, sys_count);
    do_reset(4);

    // sys_signal held high: RESUME must ignore it, the following RUN captures again.
    sysregs    = {16'h0, 16'h0, 16'd5};
    sys_signal = 1'b1;
    tick(); check("held_c1_decode", {31'd0, cpu_clk_en}, 32'd0);
    tick(); check("held_c2_resume", {15'd0, cpu_clk_en, sys_count}, {15'd0, 1'b1, 16'd1});
    check("held_err", {31'd0, err}, 32'd1);
    tick(); check("held_c3_run", {31'd0, cpu_clk_en}, 32'd1);
    tick(); check("held_c4_decode", {31'd0, cpu_clk_en}, 32'd0);
    tick(); check("held_c5_resume", {15'd0, cpu_clk_en, sys_count}, {15'd0, 1'b1, 16'd2});
    sys_signal = 1'b0;
    tick();
    $display("held syscall: clk_en=%0b err=%0b count=%0h", cpu_clk_en, err, sys_count);

    // Halt call, then verify it sticks while sys_signal keeps requesting.
    sysregs    = {16'h0, 16'h0, 16'd0};
    sys_signal = 1'b1;
    tick();
    sys_signal = 1'b0;
    tick();
    check("halt_entry", {14'd0, halted, cpu_clk_en, sys_count}, {14'd0, 1'b1, 1'b0, 16'd3});
    sysregs    = {16'h0, 16'h0, 16'd1};
    sys_signal = 1'b1;
    halt_bad   = 0;
    repeat (6) begin
      tick();
      if (!halted || cpu_clk_en || io.out_valid || sys_count !== 16'd3) halt_bad++;
    end
    sys_signal = 1'b0;
    check("halt_held", halt_bad, 32'd0);
    $display("halt: halted=%0b clk_en=%0b count=%0h", halted, cpu_clk_en, sys_count);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sys_controller.md
SYS_CONTROLLER -- requirements
Module: sys_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 SHALL have port clear, input, 1 bit: synchronous active-high reset.
REQ-003 SHALL have port sys_signal, input, 1 bit: CPU is presenting a system-call instruction.
REQ-004 SHALL have port sysregs, input, 48 bits: {r3, r2, r1}; r1 = [15:0] = call code, r2 = [31:16] = argument.
REQ-005 SHALL have port in_valid / in_data, input, 1 / 16 bits: input-port valid/ready source.
REQ-006 SHALL have port out_ready, input, 1 bit: output-port sink ready.
REQ-007 SHALL have port cpu_clk_en, output, 1 bit: CPU may advance this cycle.
REQ-008 SHALL have port cpu_clear, output, 1 bit: drives CPU clear.
REQ-009 SHALL have port load_signal / load_data, output, 1 / 16 bits: write load_data into CPU r3.
REQ-010 SHALL have port in_ready, output, 1 bit: input-port handshake.
REQ-011 SHALL have port out_valid / out_data, output, 1 / 16 bits: output-port handshake.
REQ-012 SHALL have ports halted, err, sys_count[15:0], all outputs: status.

Function
REQ-013 SHALL implement states BOOT, RUN, DECODE, OUT_WAIT, IN_WAIT, LOAD, RESUME, HALT; all outputs decoded from registered state/data only (no input-to-output combinational path).
REQ-014 BOOT: cpu_clear=1, cpu_clk_en=1 for exactly 2 cycles after clear deasserts, then RUN.
REQ-015 RUN: cpu_clk_en=1; sys_signal=1 sampled -> capture code=r1, arg=r2, go to DECODE (cpu_clk_en=0 from the next cycle).
REQ-016 DECODE (1 cycle, cpu_clk_en=0): code 0 -> HALT; 1 -> OUT_WAIT; 2 -> IN_WAIT; 3 -> OUT_WAIT and then IN_WAIT (echo-read); any other code -> set err (sticky), go to RESUME.
REQ-017 OUT_WAIT: out_valid=1, out_data=arg, held stable; transfer when out_valid&out_ready; next state IN_WAIT for code 3, else RESUME.
REQ-018 IN_WAIT: in_ready=1; on in_valid&in_ready capture in_data, go to LOAD.
REQ-019 LOAD (1 cycle): load_signal=1, load_data=captured word, cpu_clk_en=0, then RESUME.
REQ-020 RESUME (1 cycle): cpu_clk_en=1, sys_signal ignored, sys_count increments by 1 (wraps 0xFFFF->0x0000), then RUN.
REQ-021 HALT: cpu_clk_en=0, halted=1, sys_count increments once on entry; held until clear.
REQ-022 load_signal SHALL never be 1 outside LOAD; load_data=0 when load_signal=0.
REQ-023 out_valid, once asserted, SHALL NOT drop, and out_data SHALL NOT change, until transfer or clear.
REQ-024 Zero-wait handshakes (out_ready or in_valid already high on state entry) SHALL complete in that first cycle.
REQ-025 Any syscall: exactly one cpu_clk_en=1 cycle (RESUME) between sys_signal capture and RUN.

Reset
REQ-026 clear=1 in any state -> next state BOOT; cpu_clear=1, cpu_clk_en=1, load_signal=0, in_ready=0, out_valid=0, out_data=0, load_data=0, halted=0, err=0, sys_count=0; pending capture discarded.
REQ-027 Clear held multiple cycles SHALL keep BOOT with its 2-cycle count restarting at deassertion.

Verification
REQ-028 Reset: clear 3 cycles then 0 -> cpu_clear=1 for 2 further cycles, then RUN with cpu_clk_en=1, all status 0.
REQ-029 Output call: r1=1, r2=0x1234, sys_signal pulse, out_ready low 4 cycles -> out_valid=1, out_data=0x1234 stable 4 cycles, transfer, 1 RESUME cycle, sys_count=1.
REQ-030 Input call: r1=2, in_valid=1 with in_data=0xBEEF from entry -> in_ready 1 cycle, LOAD cycle with load_signal=1, load_data=0xBEEF, then RESUME; total 4 cycles after capture.
REQ-031 Echo call: r1=3, r2=0x00FF -> out transfer of 0x00FF, then input 0x0007 loaded to r3; sys_count +1.
REQ-032 Illegal/halt: r1=9 -> err=1, CPU resumes; then r1=0 -> halted=1, cpu_clk_en=0 indefinitely, sys_count=2.
REQ-033 clear asserted mid-OUT_WAIT -> out_valid=0 next cycle, BOOT sequence, sys_count=0; 65536 syscalls wrap sys_count to 0.
